servo_pwm_array: RTL and testbench

Multi-channel, parametrised hobby-servo PWM generator for the solar-panel tracker, driving the azimuth and elevation servos by default. A single shared frame counter generates a fixed period. Each channel's pulse width comes from a 12-bit position command, accepted over a valid/ready handshake and linearly mapped into a configurable pulse window. Each channel slews toward its new target at a bounded rate per frame, so the panel mechanics never see a full-range jump.

---
 rtl/servo_pkg.sv | 30 +++
 rtl/servo_slew_ch.sv | 56 +++++
 rtl/servo_pwm_array.sv | 135 +++++++++++++
 tb/tb_servo_pwm_array.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared constants, handshake state type and position-to-width mapping helpers
// for the multi-channel servo PWM generator.
package servo_pkg;

    localparam int unsigned DEF_PERIOD_CYC = 2_500_000;
    localparam int unsigned DEF_MIN_CYC    = 125_000;
    localparam int unsigned DEF_MAX_CYC    = 250_000;
    localparam int unsigned DEF_STEP_CYC   = 2_500;
    localparam int unsigned DEF_CENTER     = (DEF_MIN_CYC + DEF_MAX_CYC) / 2;
    localparam int unsigned DEF_POS_W      = 12;

    typedef enum logic [1:0] {
        HS_READY = 2'd0,
        HS_WAIT1 = 2'd1,
        HS_WAIT2 = 2'd2
    } hs_state_t;

    // Full-precision product pos * (MAX - MIN); callers narrow to POS_W + CNT_W.
    function automatic logic [63:0] map_product(input logic [31:0] pos, input logic [31:0] span);
        return 64'(pos) * 64'(span);
    endfunction

    // Final width: MIN + (product >> POS_W), always inside [MIN, MAX).
    function automatic logic [63:0] map_width(input logic [63:0] prod,
                                              input logic [31:0] min_cyc,
                                              input int unsigned pos_w);
        return 64'(min_cyc) + (prod >> pos_w);
    endfunction

endpackage

// File: rtl/servo_slew_ch.sv
// One servo channel: target/current width registers, per-frame rate-limited
// slew, and the registered pwm and at_target outputs.
module servo_slew_ch
    import servo_pkg::*;
#(
    parameter int unsigned CNT_W    = 22,
    parameter int unsigned STEP_CYC = DEF_STEP_CYC,
    parameter int unsigned CENTER   = DEF_CENTER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             boundary,
    input  logic [CNT_W-1:0] cnt,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] width,
    output logic             pwm,
    output logic             at_target
);

    localparam logic [CNT_W-1:0] STEP   = CNT_W'(STEP_CYC);
    localparam logic [CNT_W-1:0] CENTRE = CNT_W'(CENTER);

    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] cur;
    logic [CNT_W-1:0] target_d;
    logic [CNT_W-1:0] cur_d;

    // Slew uses the pre-write target, so a write on the boundary cycle waits a frame.
    always_comb begin
        target_d = wr ? width : target;
        cur_d    = cur;
        if (boundary) begin
            if (target > cur) begin
                cur_d = ((target - cur) <= STEP) ? target : cur + STEP;
            end else if (cur > target) begin
                cur_d = ((cur - target) <= STEP) ? target : cur - STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target    <= CENTRE;
            cur       <= CENTRE;
            at_target <= 1'b1;
            pwm       <= 1'b0;
        end else begin
            target    <= target_d;
            cur       <= cur_d;
            at_target <= (cur_d == target_d);
            pwm       <= en && (cnt < cur);
        end
    end

endmodule

// File: rtl/servo_pwm_array.sv
// Multi-channel servo PWM generator: shared frame counter, valid/ready command
// intake, two-stage position mapping pipeline and per-channel slew instances.
module servo_pwm_array
    import servo_pkg::*;
#(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC,
    parameter int unsigned MIN_CYC    = DEF_MIN_CYC,
    parameter int unsigned MAX_CYC    = DEF_MAX_CYC,
    parameter int unsigned POS_W      = DEF_POS_W,
    parameter int unsigned STEP_CYC   = DEF_STEP_CYC,
    parameter int unsigned CNT_W      = $clog2(PERIOD_CYC),
    parameter int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CH_W-1:0]  cmd_ch,
    input  logic [POS_W-1:0] cmd_pos,
    input  logic [N_CH-1:0]  ch_en,
    output logic [N_CH-1:0]  pwm,
    output logic [N_CH-1:0]  at_target,
    output logic             frame_start,
    output logic             cmd_err
);

    localparam int unsigned PROD_W = POS_W + CNT_W;
    localparam int unsigned SPAN   = MAX_CYC - MIN_CYC;
    localparam int unsigned CENTER = (MIN_CYC + MAX_CYC) / 2;

    logic [CNT_W-1:0] cnt;
    logic             boundary_c;

    hs_state_t state;
    hs_state_t state_d;
    logic      accept_c;

    logic              s1_valid;
    logic [CH_W-1:0]   s1_ch;
    logic [PROD_W-1:0] s1_prod;
    logic              s1_ch_ok_c;
    logic              s2_valid;
    logic [CH_W-1:0]   s2_ch;
    logic [CNT_W-1:0]  s2_width;

    // Free-running frame counter; frame_start is high while cnt is 0.
    assign boundary_c = (cnt == CNT_W'(PERIOD_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            frame_start <= 1'b0;
        end else begin
            cnt         <= boundary_c ? '0 : cnt + CNT_W'(1);
            frame_start <= boundary_c;
        end
    end

    // Handshake: two dead cycles after each accept while the pipeline drains.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HS_WAIT2;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_d;
            cmd_ready <= (state_d == HS_READY);
        end
    end

    always_comb begin
        state_d  = state;
        accept_c = 1'b0;
        case (state)
            HS_READY: begin
                if (cmd_valid) begin
                    accept_c = 1'b1;
                    state_d  = HS_WAIT1;
                end
            end
            HS_WAIT1: state_d = HS_WAIT2;
            HS_WAIT2: state_d = HS_READY;
            default:  state_d = HS_READY;
        endcase
    end

    // Stage 1 holds the full-width product, stage 2 the final width and write strobe.
    assign s1_ch_ok_c = (32'(s1_ch) < N_CH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_prod  <= '0;
            s2_valid <= 1'b0;
            s2_ch    <= '0;
            s2_width <= '0;
            cmd_err  <= 1'b0;
        end else begin
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_ch   <= cmd_ch;
                s1_prod <= PROD_W'(map_product(32'(cmd_pos), SPAN));
            end
            s2_valid <= s1_valid && s1_ch_ok_c;
            cmd_err  <= s1_valid && !s1_ch_ok_c;
            if (s1_valid) begin
                s2_ch    <= s1_ch;
                s2_width <= CNT_W'(map_width(64'(s1_prod), MIN_CYC, POS_W));
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic wr_c;
        assign wr_c = s2_valid && (s2_ch == CH_W'(i));

        servo_slew_ch #(
            .CNT_W    (CNT_W),
            .STEP_CYC (STEP_CYC),
            .CENTER   (CENTER)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .boundary  (boundary_c),
            .cnt       (cnt),
            .en        (ch_en[i]),
            .wr        (wr_c),
            .width     (s2_width),
            .pwm       (pwm[i]),
            .at_target (at_target[i])
        );
    end

endmodule

// File: tb/tb_servo_pwm_array.sv
// Scoreboard bench for servo_pwm_array with a shortened frame: measures every
// pulse width per frame against a bench-side slew model.
module tb_servo_pwm_array;

    localparam int NCH    = 3;
    localparam int PERIOD = 400;
    localparam int MINC   = 100;
    localparam int MAXC   = 300;
    localparam int STEP   = 10;
    localparam int CTR    = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_ch;
    logic [11:0] cmd_pos;
    logic [2:0] ch_en;
    logic [2:0] pwm;
    logic [2:0] at_target;
    logic       frame_start;
    logic       cmd_err;

    typedef struct {
        int ch;
        int width;
    } sb_t;

    sb_t sb[$];
    int  mcur [NCH];
    int  mtgt [NCH];
    int  meas [NCH];
    int  n_cmp = 0;
    int  n_err = 0;

    servo_pwm_array #(
        .N_CH       (NCH),
        .PERIOD_CYC (PERIOD),
        .MIN_CYC    (MINC),
        .MAX_CYC    (MAXC),
        .POS_W      (12),
        .STEP_CYC   (STEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_ch      (cmd_ch),
        .cmd_pos     (cmd_pos),
        .ch_en       (ch_en),
        .pwm         (pwm),
        .at_target   (at_target),
        .frame_start (frame_start),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic bit_at(input logic [2:0] v, input int i);
        logic [2:0] s;
        s = v >> i;
        return s[0];
    endfunction

    function automatic int slew(input int c, input int t);
        if (t > c + STEP) return c + STEP;
        if (c > t + STEP) return c - STEP;
        return t;
    endfunction

    task automatic wait_frame_start();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < PERIOD + 4);
        if (!frame_start) check_eq("frame_start_timeout", 0, 1);
    endtask

    // Counts high cycles of each pwm over cnt = 1 .. PERIOD-1.
    task automatic measure_frame();
        for (int i = 0; i < NCH; i++) meas[i] = 0;
        for (int k = 0; k < PERIOD - 1; k++) begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) if (bit_at(pwm, i)) meas[i]++;
        end
    endtask

    task automatic frame_step();
        for (int i = 0; i < NCH; i++) mcur[i] = slew(mcur[i], mtgt[i]);
        for (int i = 0; i < NCH; i++)
            check_eq($sformatf("at_target_ch%0d", i), bit_at(at_target, i), mcur[i] == mtgt[i]);
    endtask

    task automatic pop_check(input int ch, input int w);
        sb_t e;
        if (sb.size() == 0) begin
            check_eq("sb_underflow", 0, 1);
        end else begin
            e = sb.pop_front();
            check_eq("sb_ch", ch, e.ch);
            check_eq("sb_width", w, e.width);
        end
    endtask

    // Model-checks each frame; with stop_ch >= 0, stops once that channel settles.
    task automatic run_frames(input int nframes, input int stop_ch);
        logic [2:0] snap;
        for (int f = 0; f < nframes; f++) begin
            wait_frame_start();
            frame_step();
            snap = at_target;
            measure_frame();
            for (int i = 0; i < NCH; i++)
                check_eq($sformatf("width_ch%0d", i), meas[i], bit_at(ch_en, i) ? mcur[i] : 0);
            if (stop_ch >= 0 && bit_at(snap, stop_ch)) begin
                pop_check(stop_ch, meas[stop_ch]);
                return;
            end
        end
        if (stop_ch >= 0) check_eq("settle_timeout", 0, 1);
    endtask

    task automatic send_cmd(input int ch, input int pos, input int exp_w, input bit exp_err);
        int n;
        bit valid_ch;
        bit chg;
        n        = 0;
        valid_ch = (ch < NCH);
        chg      = 1'b0;
        while (!cmd_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_idle", cmd_ready, 1);
        if (valid_ch) chg = (mtgt[ch] != exp_w);
        cmd_valid = 1'b1;
        cmd_ch    = 2'(ch);
        cmd_pos   = 12'(pos);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("ready_t1", cmd_ready, 0);
        check_eq("err_t1", cmd_err, 0);
        @(negedge clk);
        check_eq("ready_t2", cmd_ready, 0);
        check_eq("err_t2", cmd_err, exp_err);
        @(negedge clk);
        check_eq("ready_t3", cmd_ready, 1);
        check_eq("err_t3", cmd_err, 0);
        if (valid_ch) begin
            check_eq("at_target_t3", bit_at(at_target, ch), !chg);
            mtgt[ch] = exp_w;
            sb.push_back('{ch: ch, width: exp_w});
        end else begin
            check_eq("at_target_invalid", at_target, 3'b111);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_pwm"}, pwm, 0);
        check_eq({tag, "_ready"}, cmd_ready, 0);
        check_eq({tag, "_at_target"}, at_target, 3'b111);
        check_eq({tag, "_frame_start"}, frame_start, 0);
        check_eq({tag, "_cmd_err"}, cmd_err, 0);
    endtask

    int tp_pos [3] = '{0, 4095, 2048};
    int tp_w   [3] = '{100, 299, 200};

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_ch    = '0;
        cmd_pos   = '0;
        ch_en     = 3'b111;
        for (int i = 0; i < NCH; i++) begin
            mcur[i] = CTR;
            mtgt[i] = CTR;
        end

        // Reset values, then first pulse one cycle after the first cnt = 0.
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b1;
        @(negedge clk);
        check_eq("first_pulse", pwm, 3'b111);
        check_eq("ready_after_rst", cmd_ready, 1);
        run_frames(1, -1);

        // Extreme and mid positions on channel 0.
        for (int k = 0; k < 3; k++) begin
            send_cmd(0, tp_pos[k], tp_w[k], 1'b0);
            run_frames(40, 0);
        end

        // Full-rate slew on channel 1 with a short final step.
        send_cmd(1, 4095, 299, 1'b0);
        run_frames(40, 1);

        // Target written on the boundary cycle: that frame keeps the old width.
        wait_frame_start();
        frame_step();
        repeat (PERIOD - 3) @(negedge clk);
        send_cmd(0, 1024, 150, 1'b0);
        check_eq("boundary_align", frame_start, 1);
        measure_frame();
        check_eq("boundary_hold", meas[0], CTR);
        run_frames(40, 0);

        // Out-of-range channel.
        send_cmd(3, 4095, 0, 1'b1);
        run_frames(2, -1);

        // Disable mid-pulse while the slew keeps running, then reset mid-slew.
        send_cmd(0, 0, 100, 1'b0);
        run_frames(1, -1);
        wait_frame_start();
        frame_step();
        repeat (50) @(negedge clk);
        check_eq("pwm_before_dis", pwm, 3'b111);
        ch_en = 3'b110;
        @(negedge clk);
        check_eq("pwm_after_dis", pwm, 3'b110);
        run_frames(2, -1);
        check_eq("slewing_before_rst", at_target[0], 0);
        repeat (100) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        ch_en = 3'b111;
        rst   = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            mcur[i] = CTR;
            mtgt[i] = CTR;
        end
        sb.delete();
        run_frames(2, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
